// File: rtl/unscale_and_expand.sv
// Undoes a signed Q16 gain: q = trunc((x << 16) / g), computed by a 32-step
// restoring divider and saturated into a sign-extended 64-bit AXI-Stream word.
module unscale_and_expand #(
    parameter int S_AXIS_DATA_WIDTH = 16,
    parameter int M_AXIS_DATA_WIDTH = 64,
    parameter int START_BIT         = 31,
    parameter int GAIN_DATA_WIDTH   = 32,
    parameter int GAIN_DATA_Q       = 16
) (
    input  logic                         a_clk,
    input  logic                         a_rst,
    input  logic [S_AXIS_DATA_WIDTH-1:0] S_AXIS_tdata,
    input  logic                         S_AXIS_tvalid,
    output logic                         S_AXIS_tready,
    input  logic [GAIN_DATA_WIDTH-1:0]   gain,
    output logic [M_AXIS_DATA_WIDTH-1:0] M_AXIS_tdata,
    output logic                         M_AXIS_tvalid,
    input  logic                         M_AXIS_tready
);

    localparam int RW = START_BIT + 1;
    localparam int CW = $clog2(RW);
    localparam logic [RW-1:0] MAX_POS = {1'b0, {(RW-1){1'b1}}};
    localparam logic [RW-1:0] MIN_NEG = {1'b1, {(RW-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, DIV, FIX, OUT} state_t;

    state_t                       r_state;
    state_t                       w_state_next;
    logic [RW-1:0]                r_quo;
    logic [RW-1:0]                r_rem;
    logic [GAIN_DATA_WIDTH-1:0]   r_div;
    logic                         r_neg;
    logic                         r_zero;
    logic [CW-1:0]                r_cnt;
    logic [RW-1:0]                r_q;

    logic [S_AXIS_DATA_WIDTH-1:0] w_x_mag;
    logic [RW-1:0]                w_dvd_init;
    logic [GAIN_DATA_WIDTH-1:0]   w_g_mag;
    logic [RW:0]                  w_shift;
    logic                         w_ge;
    logic [RW-1:0]                w_diff;
    logic [RW-1:0]                w_rem_next;
    logic [RW-1:0]                w_fix;
    logic [RW-1:0]                w_q_out;

    // Magnitudes; negating the most negative value yields its unsigned magnitude.
    assign w_x_mag    = S_AXIS_tdata[S_AXIS_DATA_WIDTH-1] ? -S_AXIS_tdata : S_AXIS_tdata;
    assign w_dvd_init = RW'({w_x_mag, {GAIN_DATA_Q{1'b0}}});
    assign w_g_mag    = gain[GAIN_DATA_WIDTH-1] ? -gain : gain;

    // One restoring step: shift in the next dividend bit, subtract if it fits.
    // A zero divisor always "fits", producing an all-ones quotient that saturates.
    assign w_shift    = {r_rem, r_quo[RW-1]};
    assign w_ge       = w_shift >= (RW+1)'(r_div);
    assign w_diff     = w_shift[RW-1:0] - RW'(r_div);
    assign w_rem_next = w_ge ? w_diff : w_shift[RW-1:0];

    always_comb begin
        w_fix = '0;
        if (r_zero) begin
            w_fix = '0;
        end else if (r_neg) begin
            w_fix = (r_quo > MIN_NEG) ? MIN_NEG : -r_quo;
        end else begin
            w_fix = (r_quo > MAX_POS) ? MAX_POS : r_quo;
        end
    end

    always_ff @(posedge a_clk) begin
        if (a_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (S_AXIS_tvalid) w_state_next = DIV;
            DIV:     if (r_cnt == CW'(RW-1)) w_state_next = FIX;
            FIX:     w_state_next = OUT;
            OUT:     if (M_AXIS_tready) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_comb begin
        S_AXIS_tready = (r_state == IDLE) && !a_rst;
        M_AXIS_tvalid = (r_state == OUT) && !a_rst;
    end

    always_ff @(posedge a_clk) begin
        if (a_rst) begin
            r_cnt  <= '0;
            r_q    <= '0;
            r_quo  <= '0;
            r_rem  <= '0;
            r_div  <= '0;
            r_neg  <= 1'b0;
            r_zero <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (S_AXIS_tvalid) begin
                        r_quo  <= w_dvd_init;
                        r_rem  <= '0;
                        r_div  <= w_g_mag;
                        r_neg  <= S_AXIS_tdata[S_AXIS_DATA_WIDTH-1] ^ gain[GAIN_DATA_WIDTH-1];
                        r_zero <= (S_AXIS_tdata == '0);
                        r_cnt  <= '0;
                    end
                end
                DIV: begin
                    r_rem <= w_rem_next;
                    r_quo <= {r_quo[RW-2:0], w_ge};
                    r_cnt <= r_cnt + 1'b1;
                end
                FIX: r_q <= w_fix;
                default: ;
            endcase
        end
    end

    assign w_q_out = a_rst ? '0 : r_q;

    // Upper output bits replicate the result sign.
    genvar gi;
    generate
        for (gi = 0; gi < M_AXIS_DATA_WIDTH; gi++) begin : g_ext
            if (gi < RW) begin : g_lo
                assign M_AXIS_tdata[gi] = w_q_out[gi];
            end else begin : g_hi
                assign M_AXIS_tdata[gi] = w_q_out[RW-1];
            end
        end
    endgenerate

endmodule

// File: tb/tb_unscale_and_expand.sv
// Table-driven bench with an output scoreboard for unscale_and_expand,
// plus hand sequences for backpressure and reset during the divide.
module tb_unscale_and_expand;

    logic        clk = 1'b0;
    logic        a_rst;
    logic [15:0] S_AXIS_tdata;
    logic        S_AXIS_tvalid;
    logic        S_AXIS_tready;
    logic [31:0] gain;
    logic [63:0] M_AXIS_tdata;
    logic        M_AXIS_tvalid;
    logic        M_AXIS_tready;

    typedef struct {
        string       name;
        logic [15:0] x;
        logic [31:0] g;
        logic [63:0] exp;
    } vec_t;

    vec_t        vecs[$];
    logic [63:0] sb[$];
    int          checks = 0;
    int          errors = 0;
    int          n_xfer = 0;

    always #5 clk = ~clk;

    unscale_and_expand dut (
        .a_clk         (clk),
        .a_rst         (a_rst),
        .S_AXIS_tdata  (S_AXIS_tdata),
        .S_AXIS_tvalid (S_AXIS_tvalid),
        .S_AXIS_tready (S_AXIS_tready),
        .gain          (gain),
        .M_AXIS_tdata  (M_AXIS_tdata),
        .M_AXIS_tvalid (M_AXIS_tvalid),
        .M_AXIS_tready (M_AXIS_tready)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", name, act, exp);
        end
    endtask

    task automatic add(input string name, input logic [15:0] x, input logic [31:0] g,
                       input logic [63:0] exp);
        vec_t v;
        v.name = name;
        v.x    = x;
        v.g    = g;
        v.exp  = exp;
        vecs.push_back(v);
    endtask

    // Output monitor: a transfer happens on the next rising edge.
    always @(negedge clk) begin
        if (!a_rst && M_AXIS_tvalid && M_AXIS_tready) begin
            logic [63:0] e;
            n_xfer++;
            if (sb.size() == 0) begin
                check("unexpected_output", M_AXIS_tdata, 64'hx);
            end else begin
                e = sb.pop_front();
                $display("xfer %0d: tdata=0x%016h expected=0x%016h", n_xfer, M_AXIS_tdata, e);
                check("tdata", M_AXIS_tdata, e);
            end
        end
    end

    // Present a sample, push its expected result, and return just after the accepting edge.
    task automatic accept(input logic [15:0] x, input logic [31:0] g, input logic [63:0] exp);
        int n = 0;
        while (!S_AXIS_tready && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("accept_ready", 64'(S_AXIS_tready), 64'd1);
        S_AXIS_tdata  = x;
        gain          = g;
        S_AXIS_tvalid = 1'b1;
        sb.push_back(exp);
        @(posedge clk);
        #1;
        S_AXIS_tvalid = 1'b0;
        S_AXIS_tdata  = 16'($urandom);
        gain          = $urandom;
    endtask

    // Counts rising edges, with the accepting edge as clock 1, until tvalid is seen.
    task automatic wait_valid(output int lat);
        lat = 1;
        while (!M_AXIS_tvalid && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int seen;

        add("unity",        16'h1000, 32'h0001_0000, 64'h0000_0000_0000_1000);
        add("neg_half",     16'hF000, 32'h0002_0000, 64'hFFFF_FFFF_FFFF_F800);
        add("trunc_pos",    16'h0007, 32'h0003_0000, 64'h0000_0000_0000_0002);
        add("trunc_neg",    16'hFFF9, 32'h0003_0000, 64'hFFFF_FFFF_FFFF_FFFE);
        add("min_neg",      16'h8000, 32'h0000_0001, 64'hFFFF_FFFF_8000_0000);
        add("sat_pos",      16'h8000, 32'hFFFF_FFFF, 64'h0000_0000_7FFF_FFFF);
        add("g0_pos",       16'h0005, 32'h0000_0000, 64'h0000_0000_7FFF_FFFF);
        add("g0_neg",       16'hFFFB, 32'h0000_0000, 64'hFFFF_FFFF_8000_0000);
        add("g0_zero",      16'h0000, 32'h0000_0000, 64'h0000_0000_0000_0000);
        add("x0_negg",      16'h0000, 32'hFFFF_0000, 64'h0000_0000_0000_0000);
        add("gmin",         16'h8000, 32'h8000_0000, 64'h0000_0000_0000_0001);
        add("half_gain",    16'h4000, 32'h0000_8000, 64'h0000_0000_0000_8000);
        add("neg_gain",     16'h0064, 32'hFFFE_0000, 64'hFFFF_FFFF_FFFF_FFCE);
        add("to_zero",      16'h0001, 32'h0003_0000, 64'h0000_0000_0000_0000);
        add("big_q",        16'h7FFF, 32'h0000_0002, 64'h0000_0000_3FFF_8000);
        add("max_x_g1",     16'h7FFF, 32'h0000_0001, 64'h0000_0000_7FFF_0000);
        add("neg_to_zero",  16'hFFFF, 32'h7FFF_FFFF, 64'h0000_0000_0000_0000);

        a_rst         = 1'b1;
        S_AXIS_tdata  = 16'h1234;
        S_AXIS_tvalid = 1'b0;
        gain          = 32'h0001_0000;
        M_AXIS_tready = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        check("rst_s_tready", 64'(S_AXIS_tready), 64'd0);
        check("rst_m_tvalid", 64'(M_AXIS_tvalid), 64'd0);
        check("rst_m_tdata",  M_AXIS_tdata,       64'd0);
        a_rst = 1'b0;
        @(negedge clk);
        check("ready_after_rst", 64'(S_AXIS_tready), 64'd1);

        // Back-to-back table: accept, latency, transfer, ready again on the next clock.
        foreach (vecs[i]) begin
            accept(vecs[i].x, vecs[i].g, vecs[i].exp);
            wait_valid(lat);
            check({vecs[i].name, "_latency"}, 64'(lat), 64'd34);
            @(posedge clk);
            #1;
            check({vecs[i].name, "_ready_next"}, 64'(S_AXIS_tready), 64'd1);
        end

        // Backpressure held for 10 clocks in OUT.
        M_AXIS_tready = 1'b0;
        accept(16'hF000, 32'h0002_0000, 64'hFFFF_FFFF_FFFF_F800);
        wait_valid(lat);
        check("bp_latency", 64'(lat), 64'd34);
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            check("bp_tdata",    M_AXIS_tdata,             64'hFFFF_FFFF_FFFF_F800);
            check("bp_tvalid",   64'(M_AXIS_tvalid),       64'd1);
            check("bp_s_tready", 64'(S_AXIS_tready),       64'd0);
        end
        M_AXIS_tready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_tvalid_drop", 64'(M_AXIS_tvalid), 64'd0);
        check("bp_ready_next",  64'(S_AXIS_tready), 64'd1);

        // Reset pulse in the middle of the divide discards the sample.
        accept(16'h1000, 32'h0001_0000, 64'h0000_0000_0000_1000);
        void'(sb.pop_back());
        repeat (15) @(posedge clk);
        #1;
        a_rst = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_s_tready", 64'(S_AXIS_tready), 64'd0);
        check("midrst_m_tvalid", 64'(M_AXIS_tvalid), 64'd0);
        check("midrst_m_tdata",  M_AXIS_tdata,       64'd0);
        a_rst = 1'b0;
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (M_AXIS_tvalid) seen++;
        end
        check("midrst_no_output", 64'(seen), 64'd0);
        accept(16'h0007, 32'h0003_0000, 64'h0000_0000_0000_0002);
        wait_valid(lat);
        check("midrst_next_latency", 64'(lat), 64'd34);
        @(posedge clk);
        #1;
        check("midrst_ready_next", 64'(S_AXIS_tready), 64'd1);

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_drain", 64'(sb.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/unscale_and_expand.md
UNSCALE_AND_EXPAND -- requirements
Module: unscale_and_expand

Interface
REQ-001 Parameter S_AXIS_DATA_WIDTH, default 16, SHALL be the signed input sample width.
REQ-002 Parameter M_AXIS_DATA_WIDTH, default 64, SHALL be the output word width.
REQ-003 Parameter START_BIT, default 31, SHALL set the result width to START_BIT+1 = 32 bits signed.
REQ-004 Parameter GAIN_DATA_WIDTH, default 32, SHALL be the signed gain width.
REQ-005 Parameter GAIN_DATA_Q, default 16, SHALL be the number of gain fraction bits (Q16).
REQ-006 a_clk  input  1  SHALL be the single clock; all logic is on its rising edge.
REQ-007 a_rst  input  1  SHALL be the reset: synchronous, active-high.
REQ-008 S_AXIS_tdata  input  16  SHALL be the signed sample x.
REQ-009 S_AXIS_tvalid  input  1  SHALL flag that x is valid.
REQ-010 S_AXIS_tready  output  1  SHALL flag that the block accepts x this cycle.
REQ-011 gain  input  32  SHALL be the signed Q16 gain g that is to be undone.
REQ-012 M_AXIS_tdata  output  64  SHALL carry the result q, sign-extended to 64 bits.
REQ-013 M_AXIS_tvalid  output  1  SHALL flag that the result is valid.
REQ-014 M_AXIS_tready  input  1  SHALL be the downstream acceptance.

Function
REQ-015 Quotient: the block SHALL compute q = trunc_toward_zero((x * 2^16) / g), the inverse of a Q16 gain multiply.
REQ-016 Handshake: a sample SHALL transfer on a clock edge where S_AXIS_tvalid and S_AXIS_tready are both 1; gain SHALL be latched on that same edge.
REQ-017 FSM states SHALL be IDLE, DIV, FIX and OUT; S_AXIS_tready SHALL be 1 only in IDLE.
REQ-018 IDLE->DIV on acceptance; the 32-bit dividend magnitude |x|<<16, the 32-bit divisor magnitude |g| and the result sign (sign(x) XOR sign(g)) SHALL be latched.
REQ-019 DIV SHALL run a restoring unsigned divide at 1 quotient bit per clock, MSB first, controlled by a 5-bit counter; after exactly 32 iterations it SHALL move to FIX.
REQ-020 FIX SHALL apply the sign, apply saturation, load M_AXIS_tdata, and move to OUT.
REQ-021 Latency: M_AXIS_tvalid SHALL rise exactly 34 clocks after the accepting edge.
REQ-022 OUT: M_AXIS_tvalid=1; M_AXIS_tdata SHALL hold stable while M_AXIS_tready=0; the block SHALL return to IDLE on the edge with M_AXIS_tready=1.
REQ-023 Saturation: a result above 2^31-1 SHALL clamp to 0x000000007FFFFFFF; the result -2^31 SHALL pass unclamped.
REQ-024 Zero gain: when g=0, the output SHALL be 0x000000007FFFFFFF for x>0, 0xFFFFFFFF80000000 for x<0, and 0 for x=0; no divide error SHALL occur.
REQ-025 g=-2^31 SHALL be handled with divisor magnitude 2^31 and no overflow.
REQ-026 x=0 SHALL yield 0 for any g.
REQ-027 Gain changes after acceptance SHALL NOT affect the sample in flight.
REQ-028 Bits 63..31 of M_AXIS_tdata SHALL always equal the sign of q; bit 63 together with bits 30..0 SHALL reproduce the packed 32-bit format used on the forward scaling path.
REQ-029 Throughput: at most one sample per 35 clocks with M_AXIS_tready held at 1.

Reset
REQ-030 While a_rst=1: state=IDLE, M_AXIS_tvalid=0, M_AXIS_tdata=0, S_AXIS_tready=0, counter=0.
REQ-031 S_AXIS_tready SHALL become 1 on the first clock after a_rst is deasserted.
REQ-032 Reset asserted during DIV, FIX or OUT SHALL discard the sample in flight without any output transfer.

Verification
REQ-033 x=0x1000, g=0x00010000 -> M_AXIS_tdata=0x0000000000001000, with tvalid exactly 34 clocks after acceptance.
REQ-034 x=0xF000 (-4096), g=0x00020000 -> 0xFFFFFFFFFFFFF800; x=7, g=0x00030000 -> 0x2; x=-7, g=0x00030000 -> 0xFFFFFFFFFFFFFFFE.
REQ-035 x=0x8000, g=0x00000001 -> 0xFFFFFFFF80000000; x=0x8000, g=0xFFFFFFFF -> 0x000000007FFFFFFF (saturated).
REQ-036 g=0 with x=5 / -5 / 0 -> 0x7FFFFFFF / 0xFFFFFFFF80000000 / 0.
REQ-037 Backpressure: hold M_AXIS_tready=0 for 10 clocks in OUT -> tdata stable and S_AXIS_tready=0 throughout; release -> one transfer, then S_AXIS_tready=1 on the next clock.
REQ-038 Pulse a_rst at iteration 15 of DIV -> no M_AXIS_tvalid; the next sample is processed correctly with the full 34-clock latency.
